// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter merging two queued register-write streams onto one register-file
// write port, with a clear sequence that zeroes every register.
module reg_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              clr_start,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        wr_src
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic {ARB, CLEAR} state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0] mem [2][FIFO_DEPTH];
    logic [ENTRY_W-1:0] in_entry [2];
    logic [PTR_W-1:0]   wr_ptr [2];
    logic [PTR_W-1:0]   rd_ptr [2];
    logic [CNT_W-1:0]   count [2];
    logic               ready_en;
    logic [1:0]         valid, ready, push, pop, not_empty;
    logic               grant, last_grant, last_next;
    logic [ADDR_W-1:0]  clr_cnt, clr_cnt_next;
    logic               wr_en_next, busy_next;
    logic [ADDR_W-1:0]  wr_addr_next;
    logic [DATA_W-1:0]  wr_data_next;
    logic [1:0]         wr_src_next;

    assign valid       = {b_valid, a_valid};
    assign in_entry[0] = {a_addr, a_data};
    assign in_entry[1] = {b_addr, b_data};
    assign push        = valid & ready;
    assign a_ready     = ready[0];
    assign b_ready     = ready[1];

    // Readiness depends only on registered occupancy, so a pop never frees a slot early.
    always_comb begin
        ready     = '0;
        not_empty = '0;
        for (int p = 0; p < 2; p++) begin
            ready[p]     = ready_en && (count[p] < CNT_FULL);
            not_empty[p] = (count[p] != '0);
        end
    end

    always_comb begin
        state_next   = state;
        pop          = '0;
        grant        = 1'b0;
        last_next    = last_grant;
        clr_cnt_next = clr_cnt;
        wr_en_next   = 1'b0;
        wr_addr_next = '0;
        wr_data_next = '0;
        wr_src_next  = 2'd0;
        busy_next    = 1'b0;
        case (state)
            ARB: begin
                if (not_empty != 2'b00) begin
                    grant = (not_empty == 2'b11) ? ~last_grant : not_empty[1];
                    pop   = grant ? 2'b10 : 2'b01;
                    last_next = grant;
                    wr_en_next = 1'b1;
                    {wr_addr_next, wr_data_next} = mem[grant][rd_ptr[grant]];
                    wr_src_next = {1'b0, grant};
                end
                if (clr_start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                    busy_next    = 1'b1;
                end
            end
            CLEAR: begin
                wr_en_next   = 1'b1;
                wr_addr_next = clr_cnt;
                wr_src_next  = 2'd2;
                busy_next    = 1'b1;
                clr_cnt_next = clr_cnt + ADDR_W'(1);
                if (clr_cnt == ADDR_LAST) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en   <= 1'b0;
            last_grant <= 1'b1;
            clr_cnt    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_src     <= 2'd0;
            busy       <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            ready_en   <= 1'b1;
            last_grant <= last_next;
            clr_cnt    <= clr_cnt_next;
            wr_en      <= wr_en_next;
            wr_addr    <= wr_addr_next;
            wr_data    <= wr_data_next;
            wr_src     <= wr_src_next;
            busy       <= busy_next;
            for (int p = 0; p < 2; p++) begin
                if (push[p]) begin
                    wr_ptr[p] <= (wr_ptr[p] == PTR_LAST) ? '0 : wr_ptr[p] + PTR_W'(1);
                end
                if (pop[p]) begin
                    rd_ptr[p] <= (rd_ptr[p] == PTR_LAST) ? '0 : rd_ptr[p] + PTR_W'(1);
                end
                case ({push[p], pop[p]})
                    2'b10:   count[p] <= count[p] + CNT_W'(1);
                    2'b01:   count[p] <= count[p] - CNT_W'(1);
                    default: count[p] <= count[p];
                endcase
            end
        end
    end

    // Queue storage needs no reset: occupancy counters decide what is valid.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                mem[p][wr_ptr[p]] <= in_entry[p];
            end
        end
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameters SHALL be one per line:
- DATA_W, 8, width of register data.
- ADDR_W, 3, width of register address; register count is 2**ADDR_W.
- FIFO_DEPTH, 2, entries per requester queue.

REQ-002 Ports SHALL be one per line:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A write request.
- a_addr  in  ADDR_W  requester A target register.
- a_data  in  DATA_W  requester A write data.
- a_ready  out  1  requester A queue can accept.
- b_valid, b_addr, b_data, b_ready  as A, for requester B.
- clr_start  in  1  one-cycle pulse requesting a clear of all registers.
- busy  out  1  clear sequence in progress.
- wr_en  out  1  register-file write enable.
- wr_addr  out  ADDR_W  register-file write address.
- wr_data  out  DATA_W  register-file write data.
- wr_src  out  2  source of the current write: 0=A, 1=B, 2=clear.

Function
REQ-003 A transfer on port X SHALL occur at a rising edge where x_valid=1 and x_ready=1; {addr,data} is pushed into X's FIFO.
REQ-004 x_ready SHALL be 1 exactly when X's FIFO holds fewer than FIFO_DEPTH entries, evaluated from registered state only; a push to a full FIFO SHALL NOT occur even when a pop happens on the same edge.
REQ-005 Each FIFO SHALL preserve arrival order; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-006 The FSM SHALL have two states, ARB and CLEAR; reset enters ARB.
REQ-007 In ARB, at each edge with at least one FIFO non-empty, exactly one entry SHALL be popped and registered onto wr_en=1, wr_addr, wr_data and wr_src for the following cycle; otherwise wr_en=0 for that cycle.
REQ-008 Arbitration SHALL be round-robin:
- Only one FIFO non-empty: that FIFO is served.
- Both non-empty: the port not granted last is served.
- The last-grant pointer updates only on a pop.
REQ-009 Minimum latency: a push at edge N SHALL drive wr_en=1 in the cycle following edge N+1; sustained throughput SHALL be one write per cycle.
REQ-010 clr_start=1 at an edge in ARB SHALL move the FSM to CLEAR with counter=0. Any pop arbitrated at the same edge SHALL still be issued, and the clear begins on the next edge.
REQ-011 In CLEAR, each edge SHALL register wr_en=1, wr_addr=counter, wr_data=0, wr_src=2, then increment counter. After address 2**ADDR_W-1 is issued, the FSM SHALL return to ARB; the clear therefore spans 8 consecutive write cycles.
REQ-012 busy SHALL be 1 from the edge entering CLEAR through the cycle carrying the last clear write; no FIFO pops SHALL occur in CLEAR, and pushes continue per REQ-004.
REQ-013 clr_start SHALL be ignored while in CLEAR.
REQ-014 wr_en, wr_addr, wr_data, wr_src and busy SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-015 While reset=0, the block SHALL asynchronously force:
- FSM=ARB, both FIFOs empty, last-grant=B (so A wins the first tie), clear counter=0.
- wr_en=0, wr_addr=0, wr_data=0, wr_src=0, busy=0.
- a_ready=0 and b_ready=0.
REQ-016 Reset asserted mid-clear or mid-drain SHALL abort the operation with no further writes; queued entries are discarded.
REQ-017 After reset is released, a_ready and b_ready SHALL be 1 from the first rising edge onward.

Verification
REQ-018 Single write: A pushes (addr 3, data 35) at edge N -> wr_en=1, wr_addr=3, wr_data=35, wr_src=0 in the cycle after edge N+1 only.
REQ-019 Tie: A (1,53) and B (4,98) push on the same edge after reset -> A written first, B in the next cycle.
REQ-020 Backpressure: B pushes 3 entries back-to-back while A holds the grant with a continuous stream:
- b_ready=0 after 2 queued entries.
- All 3 B entries are written in order, and A/B writes alternate.
REQ-021 Clear: clr_start pulse while idle -> 8 consecutive cycles of wr_en=1, wr_addr 0..7, wr_data=0, wr_src=2, with busy=1 throughout; an A push during the clear is written after it finishes.
REQ-022 Reset mid-clear: assert reset=0 after the address-3 clear write -> outputs go to 0 immediately, no address 4..7 writes occur, and busy=0.
